// File: rtl/pipe_cache_pkg.sv
// Shared constants and fill-state encoding for the pipe_cache_data SRAM controller.
package pipe_cache_pkg;

  localparam int INDEX_WIDTH = 4;
  localparam int LINE_WIDTH  = 256;
  localparam int BEAT_WIDTH  = 64;
  localparam int WORD_WIDTH  = 32;
  localparam int NUM_WMASKS  = LINE_WIDTH / 8;
  localparam int NUM_BEATS   = LINE_WIDTH / BEAT_WIDTH;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_COLLECT,
    FILL_WRITE
  } fill_state_t;

endpackage

// File: rtl/pipe_cache_fill_buf.sv
// Assembles refill beats into one full line and holds it in WRITE until the
// top level issues it to the SRAM write port.
module pipe_cache_fill_buf #(
  parameter int INDEX_WIDTH = pipe_cache_pkg::INDEX_WIDTH,
  parameter int LINE_WIDTH  = pipe_cache_pkg::LINE_WIDTH,
  parameter int BEAT_WIDTH  = pipe_cache_pkg::BEAT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   beat_valid,
  input  logic [INDEX_WIDTH-1:0] beat_index,
  input  logic [BEAT_WIDTH-1:0]  beat_data,
  output logic                   line_valid,
  output logic [INDEX_WIDTH-1:0] line_index,
  output logic [LINE_WIDTH-1:0]  line_data,
  input  logic                   line_taken
);
  import pipe_cache_pkg::*;

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  fill_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] slot;

  assign slot       = (state == FILL_IDLE) ? '0 : cnt;
  assign line_valid = (state == FILL_WRITE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Payload registers need no reset: a line is only visible once all beats land.
  always_ff @(posedge clk) begin
    if (beat_valid && (state == FILL_IDLE))
      line_index <= beat_index;
    if (beat_valid && (state != FILL_WRITE))
      line_data[slot*BEAT_WIDTH +: BEAT_WIDTH] <= beat_data;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      FILL_IDLE: begin
        if (beat_valid) begin
          cnt_next   = CNT_W'(1);
          state_next = FILL_COLLECT;
        end
      end
      FILL_COLLECT: begin
        if (beat_valid) begin
          cnt_next = cnt + CNT_W'(1);
          if (cnt == CNT_W'(BEATS - 1))
            state_next = FILL_WRITE;
        end
      end
      FILL_WRITE: begin
        if (line_taken) begin
          cnt_next   = '0;
          state_next = FILL_IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = FILL_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/pipe_cache_data_ctrl.sv
// Port controller for the pipe_cache_data SRAM: arbitrates the write port between
// line refills and CPU stores, and sequences the read port with a 1-cycle response.
module pipe_cache_data_ctrl #(
  parameter int INDEX_WIDTH = pipe_cache_pkg::INDEX_WIDTH,
  parameter int LINE_WIDTH  = pipe_cache_pkg::LINE_WIDTH,
  parameter int BEAT_WIDTH  = pipe_cache_pkg::BEAT_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   fill_valid,
  output logic                                   fill_ready,
  input  logic [INDEX_WIDTH-1:0]                 fill_index,
  input  logic [BEAT_WIDTH-1:0]                  fill_data,
  output logic                                   fill_done,
  input  logic                                   st_valid,
  output logic                                   st_ready,
  input  logic [INDEX_WIDTH-1:0]                 st_index,
  input  logic [$clog2(LINE_WIDTH/32)-1:0]       st_word,
  input  logic [31:0]                            st_wdata,
  input  logic [3:0]                             st_wstrb,
  input  logic                                   rd_valid,
  output logic                                   rd_ready,
  input  logic [INDEX_WIDTH-1:0]                 rd_index,
  output logic                                   rd_rvalid,
  output logic [LINE_WIDTH-1:0]                  rd_rdata,
  output logic                                   sram_csb0,
  output logic [INDEX_WIDTH-1:0]                 sram_addr0,
  output logic [LINE_WIDTH/8-1:0]                sram_wmask0,
  output logic [LINE_WIDTH-1:0]                  sram_din0,
  output logic                                   sram_csb1,
  output logic [INDEX_WIDTH-1:0]                 sram_addr1,
  input  logic [LINE_WIDTH-1:0]                  sram_dout1
);
  import pipe_cache_pkg::*;

  localparam int NWM       = LINE_WIDTH / 8;
  localparam int NUM_WORDS = LINE_WIDTH / WORD_WIDTH;

  logic                   line_valid;
  logic [INDEX_WIDTH-1:0] line_index;
  logic [LINE_WIDTH-1:0]  line_data;
  logic                   line_taken;
  logic                   fill_fire;
  logic                   st_fire;
  logic                   fill_issue;
  logic                   rd_fire;

  assign fill_ready = !rst && !line_valid;
  assign st_ready   = !rst && !line_valid;
  assign fill_fire  = fill_valid && fill_ready;
  assign st_fire    = st_valid && st_ready;
  // A line caught in WRITE by reset is dropped rather than written.
  assign fill_issue = line_valid && !rst;

  pipe_cache_fill_buf #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .LINE_WIDTH  (LINE_WIDTH),
    .BEAT_WIDTH  (BEAT_WIDTH)
  ) u_fill_buf (
    .clk        (clk),
    .rst        (rst),
    .beat_valid (fill_fire),
    .beat_index (fill_index),
    .beat_data  (fill_data),
    .line_valid (line_valid),
    .line_index (line_index),
    .line_data  (line_data),
    .line_taken (line_taken)
  );

  always_comb begin
    sram_csb0   = 1'b1;
    sram_addr0  = '0;
    sram_wmask0 = '0;
    sram_din0   = '0;
    fill_done   = 1'b0;
    line_taken  = 1'b0;
    if (fill_issue) begin
      sram_csb0   = 1'b0;
      sram_addr0  = line_index;
      sram_wmask0 = '1;
      sram_din0   = line_data;
      fill_done   = 1'b1;
      line_taken  = 1'b1;
    end else if (st_fire && (st_wstrb != 4'b0)) begin
      sram_csb0   = 1'b0;
      sram_addr0  = st_index;
      sram_wmask0 = NWM'(st_wstrb) << {st_word, 2'b00};
      sram_din0   = {NUM_WORDS{st_wdata}};
    end
  end

  // The macro cannot return a same-cycle write, so a matching read waits a cycle.
  assign rd_ready   = !rst && !(!sram_csb0 && (sram_addr0 == rd_index));
  assign rd_fire    = rd_valid && rd_ready;
  assign sram_csb1  = !rd_fire;
  assign sram_addr1 = rd_index;
  assign rd_rdata   = sram_dout1;

  always_ff @(posedge clk) begin
    if (rst)
      rd_rvalid <= 1'b0;
    else
      rd_rvalid <= rd_fire;
  end

endmodule

// File: tb/tb_pipe_cache_data_ctrl.sv
// Directed bench for pipe_cache_data_ctrl with a behavioural 1W/1R registered-input SRAM.
module tb_pipe_cache_data_ctrl;

  logic         clk;
  logic         rst;
  logic         fill_valid;
  logic         fill_ready;
  logic [3:0]   fill_index;
  logic [63:0]  fill_data;
  logic         fill_done;
  logic         st_valid;
  logic         st_ready;
  logic [3:0]   st_index;
  logic [2:0]   st_word;
  logic [31:0]  st_wdata;
  logic [3:0]   st_wstrb;
  logic         rd_valid;
  logic         rd_ready;
  logic [3:0]   rd_index;
  logic         rd_rvalid;
  logic [255:0] rd_rdata;
  logic         sram_csb0;
  logic [3:0]   sram_addr0;
  logic [31:0]  sram_wmask0;
  logic [255:0] sram_din0;
  logic         sram_csb1;
  logic [3:0]   sram_addr1;
  logic [255:0] sram_dout1;

  int n_cmp  = 0;
  int n_fail = 0;

  pipe_cache_data_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .fill_valid  (fill_valid),
    .fill_ready  (fill_ready),
    .fill_index  (fill_index),
    .fill_data   (fill_data),
    .fill_done   (fill_done),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_index    (st_index),
    .st_word     (st_word),
    .st_wdata    (st_wdata),
    .st_wstrb    (st_wstrb),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_index    (rd_index),
    .rd_rvalid   (rd_rvalid),
    .rd_rdata    (rd_rdata),
    .sram_csb0   (sram_csb0),
    .sram_addr0  (sram_addr0),
    .sram_wmask0 (sram_wmask0),
    .sram_din0   (sram_din0),
    .sram_csb1   (sram_csb1),
    .sram_addr1  (sram_addr1),
    .sram_dout1  (sram_dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro: inputs registered at the edge; writes commit one edge later.
  logic [255:0] mem [16];
  logic         mem_clear;
  logic         w_en_q;
  logic [3:0]   w_addr_q;
  logic [31:0]  w_mask_q;
  logic [255:0] w_din_q;
  logic [3:0]   r_addr_q;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int m = 0; m < 16; m++) mem[m] <= '0;
    end else if (w_en_q) begin
      for (int b = 0; b < 32; b++)
        if (w_mask_q[b]) mem[w_addr_q][8*b +: 8] <= w_din_q[8*b +: 8];
    end
    w_en_q   <= !sram_csb0;
    w_addr_q <= sram_addr0;
    w_mask_q <= sram_wmask0;
    w_din_q  <= sram_din0;
    if (!sram_csb1) r_addr_q <= sram_addr1;
  end
  assign sram_dout1 = mem[r_addr_q];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] idx, input logic [255:0] exp);
    rd_valid = 1'b1;
    rd_index = idx;
    @(negedge clk);
    chk("read_ready", 256'(rd_ready), 256'(1));
    chk("read_csb1", 256'(sram_csb1), 256'(0));
    chk("read_addr1", 256'(sram_addr1), 256'(idx));
    step();
    rd_valid = 1'b0;
    @(negedge clk);
    chk("read_rvalid", 256'(rd_rvalid), 256'(1));
    chk("read_rdata", rd_rdata, exp);
    step();
  endtask

  typedef struct {
    logic        sv;
    logic [3:0]  si;
    logic [2:0]  sw;
    logic [31:0] sd;
    logic [3:0]  ss;
    logic        rv;
    logic [3:0]  ri;
    logic        e_csb0;
    logic [3:0]  e_addr0;
    logic [31:0] e_wmask;
    logic        e_rd_ready;
    logic        e_csb1;
  } vec_t;

  vec_t vecs[5];
  logic [255:0] exp_l [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bb;
    for (int m = 0; m < 16; m++) exp_l[m] = '0;
    exp_l[5]  = {64'h4, 64'h3, 64'h2, 64'h1};
    exp_l[3]  = {160'h0, 32'h00AD00EF, 64'h0};
    exp_l[4]  = {32'hCA000000, 224'h0};
    exp_l[7]  = {192'h0, 32'h99AABBCC, 32'h11223344};
    exp_l[9]  = {64'h94, 64'h93, 64'h92, 64'h91};
    exp_l[10] = {64'h0D0D0D0D0D0D0D0D, 64'h0C0C0C0C0C0C0C0C,
                 64'h0B0B0B0B0B0B0B0B, 64'h0A0A7788_0A0A0A0A};

    //         sv    si    sw    sd            ss       rv    ri     csb0  addr0 wmask         rdy   csb1
    vecs[0] = '{1'b1, 4'd3, 3'd2, 32'hDEADBEEF, 4'b0101, 1'b0, 4'd0, 1'b0, 4'd3, 32'h00000500, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 4'd7, 3'd0, 32'h11223344, 4'b1111, 1'b1, 4'd8, 1'b0, 4'd7, 32'h0000000F, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 4'd4, 3'd7, 32'hA5A5A5A5, 4'b0000, 1'b0, 4'd0, 1'b1, 4'd0, 32'h00000000, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 4'd4, 3'd7, 32'hCAFEF00D, 4'b1000, 1'b0, 4'd0, 1'b0, 4'd4, 32'h80000000, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 4'd0, 3'd0, 32'h00000000, 4'b0000, 1'b1, 4'd3, 1'b1, 4'd0, 32'h00000000, 1'b1, 1'b0};

    // Reset with every request asserted: nothing may leak through.
    mem_clear = 1'b1;
    rst = 1'b1;
    fill_valid = 1'b1; fill_index = 4'd1; fill_data = 64'h1;
    st_valid = 1'b1; st_index = 4'd1; st_word = 3'd0; st_wdata = 32'hFFFFFFFF; st_wstrb = 4'hF;
    rd_valid = 1'b1; rd_index = 4'd1;
    step();
    step();
    @(negedge clk);
    chk("rst_fill_ready", 256'(fill_ready), 256'(0));
    chk("rst_st_ready", 256'(st_ready), 256'(0));
    chk("rst_rd_ready", 256'(rd_ready), 256'(0));
    chk("rst_csb0", 256'(sram_csb0), 256'(1));
    chk("rst_csb1", 256'(sram_csb1), 256'(1));
    chk("rst_wmask0", 256'(sram_wmask0), 256'(0));
    chk("rst_fill_done", 256'(fill_done), 256'(0));
    chk("rst_rvalid", 256'(rd_rvalid), 256'(0));
    step();
    rst = 1'b0; mem_clear = 1'b0;
    fill_valid = 1'b0; st_valid = 1'b0; rd_valid = 1'b0; st_wstrb = 4'h0;

    // Refill index 5; index is only sampled on beat 0.
    for (int k = 0; k < 4; k++) begin
      fill_valid = 1'b1;
      fill_index = (k == 0) ? 4'd5 : 4'd15;
      fill_data  = 64'(k + 1);
      @(negedge clk);
      chk("fill5_ready", 256'(fill_ready), 256'(1));
      chk("fill5_done_early", 256'(fill_done), 256'(0));
      step();
    end
    fill_valid = 1'b0;
    @(negedge clk);
    chk("fill5_write_ready", 256'(fill_ready), 256'(0));
    chk("fill5_done", 256'(fill_done), 256'(1));
    chk("fill5_csb0", 256'(sram_csb0), 256'(0));
    chk("fill5_addr0", 256'(sram_addr0), 256'(5));
    chk("fill5_wmask0", 256'(sram_wmask0), 256'(32'hFFFFFFFF));
    chk("fill5_din0", sram_din0, exp_l[5]);
    step();
    @(negedge clk);
    chk("fill5_done_clear", 256'(fill_done), 256'(0));
    do_read(4'd5, exp_l[5]);

    // Single-cycle store/read port vectors.
    for (int i = 0; i < 5; i++) begin
      st_valid = vecs[i].sv; st_index = vecs[i].si; st_word = vecs[i].sw;
      st_wdata = vecs[i].sd; st_wstrb = vecs[i].ss;
      rd_valid = vecs[i].rv; rd_index = vecs[i].ri;
      @(negedge clk);
      chk($sformatf("vec%0d_st_ready", i), 256'(st_ready), 256'(1));
      chk($sformatf("vec%0d_csb0", i), 256'(sram_csb0), 256'(vecs[i].e_csb0));
      chk($sformatf("vec%0d_wmask0", i), 256'(sram_wmask0), 256'(vecs[i].e_wmask));
      chk($sformatf("vec%0d_rd_ready", i), 256'(rd_ready), 256'(vecs[i].e_rd_ready));
      chk($sformatf("vec%0d_csb1", i), 256'(sram_csb1), 256'(vecs[i].e_csb1));
      if (!vecs[i].e_csb0) begin
        chk($sformatf("vec%0d_addr0", i), 256'(sram_addr0), 256'(vecs[i].e_addr0));
        chk($sformatf("vec%0d_din0", i), sram_din0, {8{vecs[i].sd}});
      end
      step();
    end
    st_valid = 1'b0; rd_valid = 1'b0;
    @(negedge clk);
    chk("vec4_rvalid", 256'(rd_rvalid), 256'(1));
    chk("vec4_rdata", rd_rdata, exp_l[3]);
    step();
    do_read(4'd7, {224'h0, 32'h11223344});
    do_read(4'd4, exp_l[4]);
    do_read(4'd8, 256'h0);

    // Store presented during the WRITE cycle of a fill to the same index.
    for (int k = 0; k < 4; k++) begin
      bb = 8'(8'h0A + k);
      fill_valid = 1'b1; fill_index = 4'd10; fill_data = {8{bb}};
      step();
    end
    fill_valid = 1'b0;
    st_valid = 1'b1; st_index = 4'd10; st_word = 3'd1; st_wdata = 32'h55667788; st_wstrb = 4'b0011;
    @(negedge clk);
    chk("coll_st_ready_write", 256'(st_ready), 256'(0));
    chk("coll_fill_done", 256'(fill_done), 256'(1));
    chk("coll_fill_wmask", 256'(sram_wmask0), 256'(32'hFFFFFFFF));
    step();
    @(negedge clk);
    chk("coll_st_ready_after", 256'(st_ready), 256'(1));
    chk("coll_st_csb0", 256'(sram_csb0), 256'(0));
    chk("coll_st_addr0", 256'(sram_addr0), 256'(10));
    chk("coll_st_wmask", 256'(sram_wmask0), 256'(32'h00000030));
    chk("coll_fill_done_clear", 256'(fill_done), 256'(0));
    step();
    st_valid = 1'b0; st_wstrb = 4'h0;
    do_read(4'd10, exp_l[10]);

    // Read-after-write stall on index 7.
    st_valid = 1'b1; st_index = 4'd7; st_word = 3'd1; st_wdata = 32'h99AABBCC; st_wstrb = 4'hF;
    rd_valid = 1'b1; rd_index = 4'd7;
    @(negedge clk);
    chk("raw_rd_ready_stall", 256'(rd_ready), 256'(0));
    chk("raw_csb1_stall", 256'(sram_csb1), 256'(1));
    chk("raw_csb0", 256'(sram_csb0), 256'(0));
    step();
    st_valid = 1'b0; st_wstrb = 4'h0;
    @(negedge clk);
    chk("raw_rd_ready_go", 256'(rd_ready), 256'(1));
    chk("raw_csb1_go", 256'(sram_csb1), 256'(0));
    step();
    rd_valid = 1'b0;
    @(negedge clk);
    chk("raw_rvalid", 256'(rd_rvalid), 256'(1));
    chk("raw_rdata", rd_rdata, exp_l[7]);
    step();

    // Reset after two beats to index 9, with a read also presented.
    for (int k = 0; k < 2; k++) begin
      fill_valid = 1'b1; fill_index = 4'd9; fill_data = 64'hEEEEEEEEEEEEEEEE;
      step();
    end
    rst = 1'b1; rd_valid = 1'b1; rd_index = 4'd5;
    @(negedge clk);
    chk("midrst_fill_ready", 256'(fill_ready), 256'(0));
    chk("midrst_rd_ready", 256'(rd_ready), 256'(0));
    chk("midrst_csb0", 256'(sram_csb0), 256'(1));
    chk("midrst_fill_done", 256'(fill_done), 256'(0));
    step();
    rst = 1'b0; fill_valid = 1'b0; rd_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("midrst_idle%0d_csb0", c), 256'(sram_csb0), 256'(1));
      if (c == 0) chk("midrst_rvalid", 256'(rd_rvalid), 256'(0));
      step();
    end
    for (int k = 0; k < 4; k++) begin
      fill_valid = 1'b1; fill_index = 4'd9; fill_data = 64'(8'h91 + k);
      @(negedge clk);
      chk($sformatf("refill9_beat%0d_ready", k), 256'(fill_ready), 256'(1));
      chk($sformatf("refill9_beat%0d_done", k), 256'(fill_done), 256'(0));
      step();
    end
    fill_valid = 1'b0;
    @(negedge clk);
    chk("refill9_done", 256'(fill_done), 256'(1));
    chk("refill9_din0", sram_din0, exp_l[9]);
    step();
    do_read(4'd9, exp_l[9]);

    // Reset landing on the WRITE cycle drops the line.
    for (int k = 0; k < 4; k++) begin
      fill_valid = 1'b1; fill_index = 4'd12; fill_data = 64'(8'hC1 + k);
      step();
    end
    fill_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("wrrst_csb0", 256'(sram_csb0), 256'(1));
    chk("wrrst_fill_done", 256'(fill_done), 256'(0));
    step();
    rst = 1'b0;
    do_read(4'd12, 256'h0);

    // Back-to-back reads of every index.
    for (int i = 0; i <= 16; i++) begin
      rd_valid = (i < 16);
      rd_index = 4'(i);
      @(negedge clk);
      if (i < 16) chk($sformatf("b2b_ready%0d", i), 256'(rd_ready), 256'(1));
      if (i > 0) begin
        chk($sformatf("b2b_rvalid%0d", i - 1), 256'(rd_rvalid), 256'(1));
        chk($sformatf("b2b_rdata%0d", i - 1), rd_rdata, exp_l[i-1]);
      end
      step();
    end
    @(negedge clk);
    chk("b2b_rvalid_end", 256'(rd_rvalid), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
